// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, LSU state encoding and request legality check.
package cpu_pkg;
    localparam int IW = 32;
    localparam int RW = 5;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Unsigned widths exist only for loads; halves and words must be naturally aligned.
    function automatic logic req_legal(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !wr;
            F3_H:    ok = !lo[0];
            F3_HU:   ok = !wr && !lo[0];
            F3_W:    ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction
endpackage

// File: rtl/cpu_lsu_align.sv
// rtl/cpu_lsu_align.sv - byte-enable/store-lane replication and load extraction/extension.
module cpu_lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]    funct3,
    input  logic [1:0]    addr_lo,
    input  logic [IW-1:0] wrdata,
    input  logic [IW-1:0] rddata,
    output logic [3:0]    byte_en,
    output logic [IW-1:0] wrdata_rep,
    output logic [IW-1:0] ld_data
);
    logic [IW-1:0] shifted;

    always_comb begin
        shifted    = rddata >> {addr_lo, 3'b000};
        byte_en    = 4'b1111;
        wrdata_rep = wrdata;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << addr_lo;
                wrdata_rep = {4{wrdata[7:0]}};
            end
            2'b01: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wrdata_rep = {2{wrdata[15:0]}};
            end
            default: ;
        endcase
        case (funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end
endmodule

// File: rtl/cpu_lsu.sv
// rtl/cpu_lsu.sv - load/store unit: request capture, Avalon-style bus command, load write-back.
module cpu_lsu
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_wr,
    input  logic [2:0]    i_req_funct3,
    input  logic [IW-1:0] i_req_addr,
    input  logic [IW-1:0] i_req_wrdata,
    input  logic [RW-1:0] i_req_rd,
    output logic [IW-1:0] o_ldst_addr,
    output logic          o_ldst_rd,
    output logic          o_ldst_wr,
    output logic [IW-1:0] o_ldst_wrdata,
    output logic [3:0]    o_ldst_byte_en,
    input  logic [IW-1:0] i_ldst_rddata,
    input  logic          i_ldst_waitrequest,
    output logic          o_wb_valid,
    output logic [RW-1:0] o_wb_rd,
    output logic [IW-1:0] o_wb_data,
    output logic          o_exc
);
    lsu_state_t    state, state_nx;
    logic          wr_q;
    logic [2:0]    f3_q;
    logic [1:0]    lo_q;
    logic [RW-1:0] rd_q;

    logic          idle, fire, legal;
    logic [2:0]    al_f3;
    logic [1:0]    al_lo;
    logic [3:0]    al_be;
    logic [IW-1:0] al_wrdata, al_ld;

    assign idle        = (state == IDLE);
    assign o_req_ready = idle;
    assign fire        = idle && i_req_valid;
    assign legal       = req_legal(i_req_wr, i_req_funct3, i_req_addr[1:0]);

    // Store lanes are formed from the live request; extraction uses the latched fields.
    assign al_f3 = idle ? i_req_funct3    : f3_q;
    assign al_lo = idle ? i_req_addr[1:0] : lo_q;

    cpu_lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .wrdata     (i_req_wrdata),
        .rddata     (i_ldst_rddata),
        .byte_en    (al_be),
        .wrdata_rep (al_wrdata),
        .ld_data    (al_ld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fire && legal) state_nx = REQ;
            REQ:     if (!i_ldst_waitrequest) state_nx = wr_q ? IDLE : RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q           <= 1'b0;
            f3_q           <= 3'd0;
            lo_q           <= 2'd0;
            rd_q           <= '0;
            o_ldst_addr    <= '0;
            o_ldst_rd      <= 1'b0;
            o_ldst_wr      <= 1'b0;
            o_ldst_wrdata  <= '0;
            o_ldst_byte_en <= 4'd0;
            o_wb_valid     <= 1'b0;
            o_wb_rd        <= '0;
            o_wb_data      <= '0;
            o_exc          <= 1'b0;
        end else begin
            o_exc      <= 1'b0;
            o_wb_valid <= 1'b0;
            case (state)
                IDLE: if (fire) begin
                    wr_q <= i_req_wr;
                    f3_q <= i_req_funct3;
                    lo_q <= i_req_addr[1:0];
                    rd_q <= i_req_rd;
                    if (legal) begin
                        o_ldst_addr    <= {i_req_addr[IW-1:2], 2'b00};
                        o_ldst_byte_en <= al_be;
                        o_ldst_wrdata  <= al_wrdata;
                        o_ldst_rd      <= !i_req_wr;
                        o_ldst_wr      <= i_req_wr;
                    end else begin
                        o_exc <= 1'b1;
                    end
                end
                REQ: if (!i_ldst_waitrequest) begin
                    o_ldst_rd <= 1'b0;
                    o_ldst_wr <= 1'b0;
                end
                RESP: begin
                    o_wb_valid <= 1'b1;
                    o_wb_rd    <= rd_q;
                    o_wb_data  <= (rd_q == '0) ? '0 : al_ld;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_lsu.sv
// tb/tb_cpu_lsu.sv - directed self-checking bench for cpu_lsu.
module tb_cpu_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_wr = 1'b0;
    logic [2:0]  i_req_funct3 = 3'd0;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wrdata = 32'd0;
    logic [4:0]  i_req_rd = 5'd0;
    logic [31:0] o_ldst_addr;
    logic        o_ldst_rd;
    logic        o_ldst_wr;
    logic [31:0] o_ldst_wrdata;
    logic [3:0]  o_ldst_byte_en;
    logic [31:0] i_ldst_rddata = 32'd0;
    logic        i_ldst_waitrequest = 1'b0;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_exc;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cpu_lsu dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
        .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wrdata(i_req_wrdata),
        .i_req_rd(i_req_rd), .o_ldst_addr(o_ldst_addr), .o_ldst_rd(o_ldst_rd),
        .o_ldst_wr(o_ldst_wr), .o_ldst_wrdata(o_ldst_wrdata), .o_ldst_byte_en(o_ldst_byte_en),
        .i_ldst_rddata(i_ldst_rddata), .i_ldst_waitrequest(i_ldst_waitrequest),
        .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_exc(o_exc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
        i_req_valid  = 1'b1;
        i_req_wr     = wr;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wrdata = wd;
        i_req_rd     = rd;
    endtask

    task automatic load_nowait(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [4:0] rd, input logic [31:0] rdata,
                               input logic [3:0] exp_be, input logic [31:0] exp_data);
        chk({tag, " ready"}, {31'd0, o_req_ready}, 32'd1);
        present(1'b0, f3, addr, 32'h0, rd);
        tick();
        i_req_valid = 1'b0;
        chk({tag, " rd strobe"}, {31'd0, o_ldst_rd}, 32'd1);
        chk({tag, " wr strobe"}, {31'd0, o_ldst_wr}, 32'd0);
        chk({tag, " addr"}, o_ldst_addr, {addr[31:2], 2'b00});
        chk({tag, " be"}, {28'd0, o_ldst_byte_en}, {28'd0, exp_be});
        tick();
        i_ldst_rddata = rdata;
        chk({tag, " strobe drop"}, {31'd0, o_ldst_rd}, 32'd0);
        chk({tag, " no early wb"}, {31'd0, o_wb_valid}, 32'd0);
        tick();
        chk({tag, " wb valid"}, {31'd0, o_wb_valid}, 32'd1);
        chk({tag, " wb data"}, o_wb_data, exp_data);
        chk({tag, " wb rd"}, {27'd0, o_wb_rd}, {27'd0, rd});
        chk({tag, " ready at wb"}, {31'd0, o_req_ready}, 32'd1);
        tick();
        chk({tag, " wb pulse"}, {31'd0, o_wb_valid}, 32'd0);
    endtask

    task automatic expect_exc(input string tag, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr);
        present(wr, f3, addr, 32'h0, 5'd3);
        tick();
        i_req_valid = 1'b0;
        chk({tag, " exc"}, {31'd0, o_exc}, 32'd1);
        chk({tag, " no strobe"}, {30'd0, o_ldst_rd, o_ldst_wr}, 32'd0);
        chk({tag, " ready"}, {31'd0, o_req_ready}, 32'd1);
        tick();
        chk({tag, " exc pulse"}, {31'd0, o_exc}, 32'd0);
        chk({tag, " still idle"}, {30'd0, o_ldst_rd, o_ldst_wr}, 32'd0);
    endtask

    initial begin
        int pulses;
        #12;
        chk("reset ready", {31'd0, o_req_ready}, 32'd1);
        chk("reset strobes", {30'd0, o_ldst_rd, o_ldst_wr}, 32'd0);
        chk("reset wb/exc", {30'd0, o_wb_valid, o_exc}, 32'd0);
        chk("reset addr", o_ldst_addr, 32'd0);
        chk("reset wrdata", o_ldst_wrdata, 32'd0);
        chk("reset be", {28'd0, o_ldst_byte_en}, 32'd0);
        chk("reset wb data", o_wb_data, 32'd0);
        chk("reset wb rd", {27'd0, o_wb_rd}, 32'd0);
        reset = 1'b1;
        tick();

        load_nowait("LW", 3'd2, 32'h100, 5'd5, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
        load_nowait("LB", 3'd0, 32'h203, 5'd6, 32'h80FF1234, 4'h8, 32'hFFFFFF80);
        load_nowait("LBU", 3'd4, 32'h203, 5'd7, 32'h80FF1234, 4'h8, 32'h00000080);
        load_nowait("LH", 3'd1, 32'h202, 5'd8, 32'h80FF1234, 4'hC, 32'hFFFF80FF);
        load_nowait("LBU1", 3'd4, 32'h301, 5'd9, 32'h80FF1234, 4'h2, 32'h00000012);

        // SH with three waitrequest cycles; request inputs wiggle while busy.
        i_ldst_waitrequest = 1'b1;
        present(1'b1, 3'd1, 32'h42, 32'h1234ABCD, 5'd0);
        tick();
        present(1'b0, 3'd2, 32'h500, 32'hFFFFFFFF, 5'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) i_ldst_waitrequest = 1'b0;
            chk($sformatf("SH wr strobe c%0d", i), {31'd0, o_ldst_wr}, 32'd1);
            chk($sformatf("SH rd strobe c%0d", i), {31'd0, o_ldst_rd}, 32'd0);
            chk($sformatf("SH addr c%0d", i), o_ldst_addr, 32'h40);
            chk($sformatf("SH be c%0d", i), {28'd0, o_ldst_byte_en}, 32'hC);
            chk($sformatf("SH wrdata c%0d", i), o_ldst_wrdata, 32'hABCDABCD);
            chk($sformatf("SH busy c%0d", i), {31'd0, o_req_ready}, 32'd0);
            tick();
        end
        i_req_valid = 1'b0;
        chk("SH released", {31'd0, o_ldst_wr}, 32'd0);
        chk("SH ready back", {31'd0, o_req_ready}, 32'd1);
        chk("SH no wb", {31'd0, o_wb_valid}, 32'd0);

        // SB with no wait: lane replication and ready at T+2.
        present(1'b1, 3'd0, 32'h1, 32'h000000AB, 5'd0);
        tick();
        i_req_valid = 1'b0;
        chk("SB be", {28'd0, o_ldst_byte_en}, 32'h2);
        chk("SB wrdata", o_ldst_wrdata, 32'hABABABAB);
        chk("SB addr", o_ldst_addr, 32'h0);
        tick();
        chk("SB ready T+2", {31'd0, o_req_ready}, 32'd1);
        chk("SB strobe off", {31'd0, o_ldst_wr}, 32'd0);

        expect_exc("LW misalign", 1'b0, 3'd2, 32'h101);
        expect_exc("LH misalign", 1'b0, 3'd1, 32'h103);
        expect_exc("f3=3 load", 1'b0, 3'd3, 32'h100);
        expect_exc("SBU store", 1'b1, 3'd4, 32'h100);

        // Reset mid-REQ of a stalled load.
        i_ldst_waitrequest = 1'b1;
        present(1'b0, 3'd2, 32'h700, 32'h0, 5'd4);
        tick();
        i_req_valid = 1'b0;
        chk("rst pre strobe", {31'd0, o_ldst_rd}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst strobes drop", {30'd0, o_ldst_rd, o_ldst_wr}, 32'd0);
        chk("rst addr clear", o_ldst_addr, 32'd0);
        #3;
        reset = 1'b1;
        i_ldst_waitrequest = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_wb_valid) pulses++;
        end
        chk("rst no wb", pulses, 32'd0);
        chk("rst ready", {31'd0, o_req_ready}, 32'd1);

        // Back-to-back LHU, first to x0.
        present(1'b0, 3'd5, 32'h10, 32'h0, 5'd0);
        tick();
        i_req_valid = 1'b0;
        chk("B2B1 be", {28'd0, o_ldst_byte_en}, 32'h3);
        tick();
        i_ldst_rddata = 32'h56789ABC;
        tick();
        chk("B2B1 wb valid", {31'd0, o_wb_valid}, 32'd1);
        chk("B2B1 wb data x0", o_wb_data, 32'd0);
        chk("B2B1 wb rd", {27'd0, o_wb_rd}, 32'd0);
        chk("B2B ready at wb", {31'd0, o_req_ready}, 32'd1);
        present(1'b0, 3'd5, 32'h12, 32'h0, 5'd7);
        tick();
        i_req_valid = 1'b0;
        chk("B2B2 rd strobe", {31'd0, o_ldst_rd}, 32'd1);
        chk("B2B2 be", {28'd0, o_ldst_byte_en}, 32'hC);
        chk("B2B2 addr", o_ldst_addr, 32'h10);
        tick();
        tick();
        chk("B2B2 wb valid", {31'd0, o_wb_valid}, 32'd1);
        chk("B2B2 wb data", o_wb_data, 32'h00005678);
        chk("B2B2 wb rd", {27'd0, o_wb_rd}, 32'd7);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_lsu.md
Name: cpu_lsu

Overview:
- Load/store unit directly downstream of the CPU execute stage.
- Accepts one memory request per handshake: effective address, store data, funct3, destination register.
- Drives the CPU's Avalon-style read/write port (o_ldst_*, with i_ldst_waitrequest), computing byte enables and write-lane replication.
- Returns sign- or zero-extended load data to the write-back stage, and tells the pipeline to stall while busy.

Parameters:
- IW, 32, data/address width.
- RW, 5, register index width (32 registers).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_req_valid  in  1  execute stage presents a memory op.
- o_req_ready  out  1  LSU can accept; high only in IDLE.
- i_req_wr  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RISC-V funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- i_req_addr  in  IW  effective byte address (rs1 + imm).
- i_req_wrdata  in  IW  rs2 value for stores.
- i_req_rd  in  RW  load destination register.
- o_ldst_addr  out  IW  word-aligned bus address (addr & ~3).
- o_ldst_rd  out  1  bus read strobe.
- o_ldst_wr  out  1  bus write strobe.
- o_ldst_wrdata  out  IW  lane-replicated store data.
- o_ldst_byte_en  out  4  active byte lanes.
- i_ldst_rddata  in  IW  read data, valid the cycle after an accepted read.
- i_ldst_waitrequest  in  1  slave stall; the command holds while high.
- o_wb_valid  out  1  one-cycle pulse: load result ready.
- o_wb_rd  out  RW  destination register for write-back.
- o_wb_data  out  IW  extended load result.
- o_exc  out  1  one-cycle pulse: misaligned or illegal funct3; the request is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - o_ldst_rd, o_ldst_wr, o_wb_valid and o_exc are 0.
  - o_ldst_addr, o_ldst_wrdata, o_ldst_byte_en, o_wb_rd and o_wb_data are 0.
  - A transaction in flight is abandoned with no write-back.
- State IDLE: o_req_ready=1. On i_req_valid=1, latch all request fields.
  - Illegal request: funct3 not in {0,1,2,4,5} for a load or {0,1,2} for a store, or misaligned (half with addr[0]=1, word with addr[1:0]!=0). Pulse o_exc the next cycle, stay in IDLE, no bus strobe.
  - Legal request: go to REQ.
- State REQ: o_req_ready=0.
  - Assert o_ldst_rd or o_ldst_wr, with addr, byte_en and wrdata registered and stable.
  - Byte enables: byte = 1<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - Write data: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
  - While i_ldst_waitrequest=1, hold everything unchanged.
  - At the edge where waitrequest=0: drop the strobe. A store returns to IDLE; a load goes to RESP.
- State RESP: sample i_ldst_rddata.
  - Shift right by 8*addr[1:0].
  - Sign-extend from bit 7 (LB) or bit 15 (LH); zero-extend for LBU/LHU; pass LW through.
  - Register into o_wb_data / o_wb_rd with o_wb_valid=1 for exactly one cycle; go to IDLE.
  - If rd==0: o_wb_valid still pulses, o_wb_data forced to 0.
- Latency with waitrequest never asserted (request accepted at edge T):
  - Strobe high in cycle T+1.
  - Load: o_wb_valid high in cycle T+3.
  - Store: o_req_ready high again in cycle T+2.
  - Each waitrequest cycle adds one.
- Back-to-back: the cycle that o_wb_valid pulses is an IDLE cycle, so a new request is accepted in that same cycle.
- o_ldst_rd and o_ldst_wr are never high together; neither is high outside REQ.
- Changes on i_req_* while o_req_ready=0 are ignored.

Decomposition:
- Shared package cpu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - LSU state enum (IDLE, REQ, RESP).
  - Opcode localparams already used by the core.
- One natural sub-module: cpu_lsu_align, purely combinational. It computes byte_en and wrdata replication from {funct3, addr[1:0], data}, plus load extraction/extension from {funct3, addr[1:0], rddata}.

Test Plan:
- LW addr=0x100, rddata=0xDEADBEEF, waitrequest=0 -> o_ldst_rd in T+1 with addr 0x100, byte_en 4'hF; o_wb_valid in T+3 with data 0xDEADBEEF.
- LB addr=0x203 and LBU addr=0x203, rddata=0x80FF_1234 -> byte_en 4'h8; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH addr=0x42, wrdata=0x1234ABCD, waitrequest high 3 cycles -> o_ldst_wr held 4 cycles with addr 0x40, byte_en 4'hC, wrdata 0xABCDABCD, all fields stable; ready returns the cycle after release.
- LW addr=0x101 and LH addr=0x103 -> o_exc pulse, no o_ldst_rd/o_ldst_wr, o_req_ready stays 1; funct3=3 load -> o_exc.
- Reset driven low during REQ of a load with waitrequest=1 -> strobes drop immediately, no o_wb_valid afterwards, o_req_ready=1 after release.
- Two LHU loads back-to-back (addr 0x10, 0x12) with rd=0 on the first -> first o_wb_data=0; second accepted in the same cycle as the first o_wb_valid.
